pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the STRV32I core. Generates stall (hold) and flush (bubble) controls for the IF/ID register (stage 1) and the ID/EX register (stage 2), and the PC hold. Handles load-use hazards, taken-branch redirects, data-memory wait states with timeout, and trap drain. It also keeps a saturating stall-cycle counter.

---
 rtl/pipe_ctrl_pkg.sv | 14 +
 rtl/load_use_detect.sv | 26 ++
 rtl/pipe_hazard_ctrl.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline
// sequencing controller.
package pipe_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN        = 2'd0,
      ST_MEM_WAIT   = 2'd1,
      ST_TRAP_DRAIN = 2'd2
   } state_e;

   localparam int          CNT_W   = 32;
   localparam logic [4:0]  X0_ADDR = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: ID reads a register that the
// load currently in EX has not yet returned.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic [4:0] i_rs1,
   input  logic [4:0] i_rs2,
   input  logic       i_rs1_used,
   input  logic       i_rs2_used,
   input  logic [4:0] i_ex_rd,
   input  logic       i_ex_wr_en,
   input  logic       i_ex_is_load,
   output logic       o_lu
);

   logic w_rs1_hit;
   logic w_rs2_hit;
   logic w_ld_valid;

   assign w_rs1_hit  = i_rs1_used && (i_rs1 == i_ex_rd);
   assign w_rs2_hit  = i_rs2_used && (i_rs2 == i_ex_rd);
   assign w_ld_valid = i_ex_is_load && i_ex_wr_en
                       && (i_ex_rd != X0_ADDR);
   assign o_lu       = w_ld_valid && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencing for IF/ID and ID/EX: load-use,
// branch redirect, data-memory wait with timeout, trap drain.
module pipe_hazard_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT  = 16,
   parameter int DRAIN_CYCLES = 2
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [4:0]       id_rs1_addr_in,
   input  logic [4:0]       id_rs2_addr_in,
   input  logic             id_rs1_used_in,
   input  logic             id_rs2_used_in,
   input  logic [4:0]       ex_rd_addr_in,
   input  logic             ex_rf_wr_en_in,
   input  logic             ex_is_load_in,
   input  logic             branch_taken_in,
   input  logic             dmem_req_in,
   input  logic             dmem_ack_in,
   input  logic             trap_req_in,
   output logic             stall_pc_out,
   output logic             stall_reg1_out,
   output logic             stall_reg2_out,
   output logic             flush_reg1_out,
   output logic             flush_reg2_out,
   output logic             trap_ack_out,
   output logic             mem_err_out,
   output logic [1:0]       state_out,
   output logic [CNT_W-1:0] stall_cnt_out
);

   localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
   localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

   state_e           r_state;
   logic [7:0]       r_wait_cnt;
   logic [3:0]       r_drain_cnt;
   logic [CNT_W-1:0] r_stall_cnt;

   state_e     w_next;
   logic [7:0] w_wait_nxt;
   logic [3:0] w_drain_nxt;
   logic       w_lu;
   logic       w_stall_pc;
   logic       w_stall_r1;
   logic       w_stall_r2;
   logic       w_flush_r1;
   logic       w_flush_r2;
   logic       w_trap_ack;
   logic       w_mem_err;

   load_use_detect u_lu (
      .i_rs1        (id_rs1_addr_in),
      .i_rs2        (id_rs2_addr_in),
      .i_rs1_used   (id_rs1_used_in),
      .i_rs2_used   (id_rs2_used_in),
      .i_ex_rd      (ex_rd_addr_in),
      .i_ex_wr_en   (ex_rf_wr_en_in),
      .i_ex_is_load (ex_is_load_in),
      .o_lu         (w_lu)
   );

   always_comb begin
      w_stall_pc  = 1'b0;
      w_stall_r1  = 1'b0;
      w_stall_r2  = 1'b0;
      w_flush_r1  = 1'b0;
      w_flush_r2  = 1'b0;
      w_trap_ack  = 1'b0;
      w_mem_err   = 1'b0;
      w_next      = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_drain_nxt = r_drain_cnt;
      unique case (r_state)
         ST_RUN: begin
            if (trap_req_in) begin
               w_stall_pc  = 1'b1;
               w_flush_r1  = 1'b1;
               w_flush_r2  = 1'b1;
               w_next      = ST_TRAP_DRAIN;
               w_drain_nxt = 4'd0;
            end else if (dmem_req_in && !dmem_ack_in) begin
               w_stall_pc  = 1'b1;
               w_stall_r1  = 1'b1;
               w_stall_r2  = 1'b1;
               w_next      = ST_MEM_WAIT;
               w_wait_nxt  = 8'd1;
            end else if (branch_taken_in) begin
               w_flush_r1  = 1'b1;
               w_flush_r2  = 1'b1;
            end else if (w_lu) begin
               w_stall_pc  = 1'b1;
               w_stall_r1  = 1'b1;
               w_flush_r2  = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            // trap_req_in stays pending until RUN resumes
            if (dmem_ack_in) begin
               w_next = ST_RUN;
            end else begin
               w_stall_pc = 1'b1;
               w_stall_r1 = 1'b1;
               w_stall_r2 = 1'b1;
               if (r_wait_cnt == WAIT_LAST) begin
                  w_mem_err   = 1'b1;
                  w_next      = ST_TRAP_DRAIN;
                  w_drain_nxt = 4'd0;
               end else begin
                  w_wait_nxt = r_wait_cnt + 8'd1;
               end
            end
         end
         ST_TRAP_DRAIN: begin
            w_stall_pc  = 1'b1;
            w_flush_r1  = 1'b1;
            w_flush_r2  = 1'b1;
            w_drain_nxt = r_drain_cnt + 4'd1;
            if (r_drain_cnt == DRAIN_LAST) begin
               w_trap_ack = 1'b1;
               w_next     = ST_RUN;
            end
         end
         default: w_next = ST_RUN;
      endcase
      if (rst_in) begin
         w_stall_pc = 1'b0;
         w_stall_r1 = 1'b0;
         w_stall_r2 = 1'b0;
         w_flush_r1 = 1'b0;
         w_flush_r2 = 1'b0;
         w_trap_ack = 1'b0;
         w_mem_err  = 1'b0;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state     <= ST_RUN;
         r_wait_cnt  <= 8'd0;
         r_drain_cnt <= 4'd0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_next;
         r_wait_cnt  <= w_wait_nxt;
         r_drain_cnt <= w_drain_nxt;
         if (w_stall_pc && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

   assign stall_pc_out   = w_stall_pc;
   assign stall_reg1_out = w_stall_r1;
   assign stall_reg2_out = w_stall_r2;
   assign flush_reg1_out = w_flush_r1;
   assign flush_reg2_out = w_flush_r2;
   assign trap_ack_out   = w_trap_ack;
   assign mem_err_out    = w_mem_err;
   assign state_out      = r_state;
   assign stall_cnt_out  = r_stall_cnt;

endmodule
